// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the RO PUF measurement block.
// Optional feature macro: RO_PUF_DIFF_EN (adds DIFF/STABLE outputs on the top).
package ro_puf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_DRAIN,
        S_CMP,
        S_DONE
    } state_t;

    // Bit positions inside the 4-bit challenge word
    localparam int CHAL_SEL_A = 0;
    localparam int CHAL_BX_A  = 1;
    localparam int CHAL_SEL_B = 2;
    localparam int CHAL_BX_B  = 3;

    // Two synchronizer flops plus one history flop for edge detection;
    // the drain phase is this long so in-flight edges still get counted.
    localparam int SYNC_STAGES = 3;

endpackage

// File: rtl/ro_puf_compare_edge_counter.sv
// Per-RO front end: synchronizer, rising-edge detect and a saturating
// edge counter with synchronous clear and count enable.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_in,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_d, cnt_q;
    logic                   sat_d, sat_q;
    logic                   rise;

    // Oldest flop holds the previous synchronized sample
    assign rise = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];

    // Shift the asynchronous RO level into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
    end

    // Next count: clear wins, otherwise count edges and stick at the ceiling
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (en && rise && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) sat_d = 1'b1;
        end
    end

    // Counter and saturation flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/ro_puf_compare.sv
// RO PUF measurement top: applies a challenge to two RO slices, counts
// their edges over a fixed window and emits one response bit with DONE.
// Optional feature macro: RO_PUF_DIFF_EN adds MARGIN, DIFF and STABLE.
module ro_puf_compare
    import ro_puf_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WIN_CYC    = 1024,
    parameter int SETTLE_CYC = 16
`ifdef RO_PUF_DIFF_EN
    ,
    parameter int MARGIN     = 4
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [3:0]       CHAL,
    input  logic             RO_IN_A,
    input  logic             RO_IN_B,
    output logic             RO_EN,
    output logic             RO_SEL_A,
    output logic             RO_BX_A,
    output logic             RO_SEL_B,
    output logic             RO_BX_B,
    output logic             BUSY,
    output logic             DONE,
    output logic             RESP,
    output logic [CNT_W-1:0] CNT_A,
    output logic [CNT_W-1:0] CNT_B,
    output logic             SAT
`ifdef RO_PUF_DIFF_EN
    ,
    output logic [CNT_W-1:0] DIFF,
    output logic             STABLE
`endif
);

    localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic [3:0]       chal_q;
    logic             ro_en_q, busy_q, done_q, resp_q;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             sat_a, sat_b;
    logic             accept, cnt_clr, cnt_en;

    assign accept  = (state_q == S_IDLE) && START;
    assign cnt_clr = accept;
    // Drain keeps counting so edges still inside the synchronizer land
    assign cnt_en  = (state_q == S_RUN) || (state_q == S_DRAIN);

`ifdef RO_PUF_DIFF_EN
    logic [CNT_W-1:0] diff_q, diff_next;
    logic             stable_q;

    // Absolute count difference, sampled into DIFF during compare
    always_comb begin
        diff_next = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
    end

    // DIFF/STABLE registers: updated only in the compare state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            diff_q   <= '0;
            stable_q <= 1'b0;
        end else if (state_q == S_CMP) begin
            diff_q   <= diff_next;
            stable_q <= (diff_next >= CNT_W'(MARGIN));
        end
    end

    assign DIFF   = diff_q;
    assign STABLE = stable_q;
`endif

    // Measurement sequencer with registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            chal_q  <= '0;
            ro_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        chal_q  <= CHAL;
                        busy_q  <= 1'b1;
                        resp_q  <= 1'b0;
                        timer_q <= TMR_W'(SETTLE_CYC - 1);
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (timer_q == '0) begin
                        ro_en_q <= 1'b1;
                        timer_q <= TMR_W'(WIN_CYC - 1);
                        state_q <= S_RUN;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                S_RUN: begin
                    if (timer_q == '0) begin
                        ro_en_q <= 1'b0;
                        timer_q <= TMR_W'(SYNC_STAGES - 1);
                        state_q <= S_DRAIN;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (timer_q == '0) state_q <= S_CMP;
                    else               timer_q <= timer_q - 1'b1;
                end
                S_CMP: begin
                    // Tie resolves to 0
                    resp_q  <= (cnt_a > cnt_b);
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (CLK),
        .rst   (RST),
        .ro_in (RO_IN_A),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt_a),
        .sat   (sat_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (CLK),
        .rst   (RST),
        .ro_in (RO_IN_B),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt_b),
        .sat   (sat_b)
    );

    assign RO_EN    = ro_en_q;
    assign RO_SEL_A = chal_q[CHAL_SEL_A];
    assign RO_BX_A  = chal_q[CHAL_BX_A];
    assign RO_SEL_B = chal_q[CHAL_SEL_B];
    assign RO_BX_B  = chal_q[CHAL_BX_B];
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign RESP     = resp_q;
    assign CNT_A    = cnt_a;
    assign CNT_B    = cnt_b;
    assign SAT      = sat_a | sat_b;

endmodule
